// File: rtl/pm_loader.sv
// pm_loader: boot-time program loader.
// Takes a byte stream (16-bit length, N high/low word pairs, XOR checksum),
// writes the words to program memory from address 0 and holds the core in
// reset until a load finishes with a matching checksum.
module pm_loader #(
  parameter int PC_WIDTH = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic                pm_we,
  output logic [PC_WIDTH-1:0] pm_addr,
  output logic [15:0]         pm_wdata,
  output logic                core_reset,
  output logic                done,
  output logic                error
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_CHECK   = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERROR   = 4'd8;

  // 17 bits so that a 16-bit address space still has a representable depth
  localparam logic [16:0] DEPTH = 17'(1) << PC_WIDTH;

  logic [3:0]          state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          acc_q, acc_d;
  logic [7:0]          hi_q, hi_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                rdy_q, rdy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                crst_q, crst_d;

  logic                fire;
  logic [15:0]         len_full;

  // Next-state and datapath; every output flop is derived from the next
  // state so outputs line up with the state they describe.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    // rdy_q always mirrors "current state accepts bytes"
    fire     = byte_valid & rdy_q;
    len_full = {len_q[15:8], byte_in};

    case (state_q)
      S_IDLE: if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (fire) begin
        len_d[15:8] = byte_in;
        state_d     = S_LEN_LO;
      end
      S_LEN_LO: if (fire) begin
        len_d = len_full;
        if (len_full == 16'd0 || {1'b0, len_full} > DEPTH) begin
          state_d = S_ERROR;
        end else begin
          addr_d  = '0;
          acc_d   = 8'd0;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (fire) begin
        hi_d    = byte_in;
        acc_d   = acc_q ^ byte_in;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (fire) begin
        wdata_d = {hi_q, byte_in};
        acc_d   = acc_q ^ byte_in;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // last word leaves the address parked on N-1; N <= depth so no wrap
        if (16'(addr_q) == len_q - 16'd1) begin
          state_d = S_CHECK;
        end else begin
          addr_d  = addr_q + PC_WIDTH'(1);
          state_d = S_DATA_HI;
        end
      end
      S_CHECK: if (fire) state_d = (byte_in == acc_q) ? S_DONE : S_ERROR;
      S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
      default: state_d = S_IDLE;
    endcase

    rdy_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
             (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
             (state_d == S_CHECK);
    we_d   = (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);
    crst_d = (state_d != S_DONE);
  end

  // State and registered outputs; reset holds the core in reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      acc_q   <= 8'd0;
      hi_q    <= 8'd0;
      addr_q  <= '0;
      wdata_q <= 16'd0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      crst_q  <= crst_d;
    end
  end

  assign byte_ready = rdy_q;
  assign pm_we      = we_q;
  assign pm_addr    = addr_q;
  assign pm_wdata   = wdata_q;
  assign core_reset = crst_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_pm_loader.sv
// tb_pm_loader: directed bench for the program loader.
// A shadow memory captures every pm_we pulse; each task drives one scenario
// and compares outputs and captured memory against hand-computed values.
module tb_pm_loader;

  localparam int PCW = 6;
  localparam int CLK = 10;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [7:0]     byte_in = 8'd0;
  logic           byte_valid = 1'b0;
  logic           byte_ready;
  logic           pm_we;
  logic [PCW-1:0] pm_addr;
  logic [15:0]    pm_wdata;
  logic           core_reset;
  logic           done;
  logic           error;

  int checks = 0;
  int errors = 0;

  logic [15:0]    mem [0:63];
  int             we_cnt = 0;
  logic [PCW-1:0] last_addr = '0;
  time            t_start = 0;
  time            t_acc = 0;

  pm_loader #(.PC_WIDTH(PCW)) dut (
    .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .pm_we(pm_we),
    .pm_addr(pm_addr), .pm_wdata(pm_wdata), .core_reset(core_reset),
    .done(done), .error(error)
  );

  always #(CLK/2) clock = ~clock;

  // Shadow program memory fed by the write port
  always @(posedge clock) begin
    if (pm_we) begin
      mem[pm_addr] = pm_wdata;
      last_addr    = pm_addr;
      we_cnt       = we_cnt + 1;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'hDEAD;
    we_cnt = 0;
  endtask

  // Pulse start for one cycle; t_start is the edge that opens the start cycle
  task automatic do_start();
    @(posedge clock);
    t_start = $time;
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Offer one byte (after an optional idle gap) and wait for it to transfer
  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 100 && !byte_ready; i++) @(negedge clock);
    if (!byte_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%h byte_ready=%b required 1", b, byte_ready);
    end else begin
      @(posedge clock);
      t_acc = $time;
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      start = 1'($urandom); byte_valid = 1'($urandom); byte_in = 8'($urandom);
    end
    @(negedge clock);
    checks++;
    if ({byte_ready, pm_we, core_reset, done, error} !== 5'b00100 || pm_addr !== '0) begin
      errors++;
      $display("FAIL reset rdy/we/crst/done/err=%b addr=%0d required 00100 addr=0",
               {byte_ready, pm_we, core_reset, done, error}, pm_addr);
    end
    start = 1'b0; byte_valid = 1'b0; byte_in = 8'd0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({byte_ready, core_reset, done, error} !== 4'b0100) begin
      errors++;
      $display("FAIL idle_after_reset rdy/crst/done/err=%b required 0100",
               {byte_ready, core_reset, done, error});
    end
  endtask

  task automatic test_good_load();
    clear_mem();
    do_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hB1, 0); send_byte(8'h0F, 0);
    send_byte(8'h98, 0);
    byte_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (mem[0] !== 16'h1234 || mem[1] !== 16'hB10F || we_cnt != 2) begin
      errors++;
      $display("FAIL good_mem m0=%h m1=%h writes=%0d required 1234 b10f 2", mem[0], mem[1], we_cnt);
    end
    checks++;
    if ({done, core_reset, error} !== 3'b100) begin
      errors++;
      $display("FAIL good_status done/crst/err=%b required 100", {done, core_reset, error});
    end
    // start cycle counts as cycle 1: 1 + 2 + 3*2 + 1 = 10
    checks++;
    if ((t_acc - t_start) / CLK != 10) begin
      errors++;
      $display("FAIL good_latency cycles=%0d required 10", (t_acc - t_start) / CLK);
    end
    checks++;
    if (pm_addr !== 6'd1) begin
      errors++;
      $display("FAIL good_addr_hold addr=%0d required 1", pm_addr);
    end
  endtask

  task automatic test_bad_checksum();
    clear_mem();
    do_start();
    // start from DONE drops done and re-holds the core
    checks++;
    if ({done, core_reset} !== 2'b01) begin
      errors++;
      $display("FAIL restart_clear done/crst=%b required 01", {done, core_reset});
    end
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hB1, 0); send_byte(8'h0F, 0);
    send_byte(8'h00, 0);
    byte_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (mem[0] !== 16'h1234 || mem[1] !== 16'hB10F || we_cnt != 2) begin
      errors++;
      $display("FAIL bad_mem m0=%h m1=%h writes=%0d required 1234 b10f 2", mem[0], mem[1], we_cnt);
    end
    checks++;
    if ({done, core_reset, error} !== 3'b011) begin
      errors++;
      $display("FAIL bad_status done/crst/err=%b required 011", {done, core_reset, error});
    end
  endtask

  task automatic test_len_bounds(input logic [15:0] n);
    clear_mem();
    do_start();
    send_byte(n[15:8], 0); send_byte(n[7:0], 0);
    byte_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({done, core_reset, error, byte_ready} !== 4'b0110) begin
      errors++;
      $display("FAIL len_%h_status done/crst/err/rdy=%b required 0110", n, {done, core_reset, error, byte_ready});
    end
    repeat (4) @(negedge clock);
    checks++;
    if (we_cnt != 0) begin
      errors++;
      $display("FAIL len_%h_writes writes=%0d required 0", n, we_cnt);
    end
  endtask

  task automatic test_full_depth();
    logic [7:0]  ck;
    logic [15:0] w;
    ck = 8'd0;
    clear_mem();
    do_start();
    send_byte(8'h00, 0); send_byte(8'h40, 0);
    for (int i = 0; i < 64; i++) begin
      w  = {8'(i), 8'(i * 3 + 1)};
      ck = ck ^ w[15:8] ^ w[7:0];
      send_byte(w[15:8], 0); send_byte(w[7:0], 0);
    end
    send_byte(ck, 0);
    byte_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (we_cnt != 64 || last_addr !== 6'd63 || pm_addr !== 6'd63) begin
      errors++;
      $display("FAIL full_writes writes=%0d last=%0d addr=%0d required 64 63 63", we_cnt, last_addr, pm_addr);
    end
    checks++;
    if (mem[0] !== 16'h0001 || mem[63] !== 16'h3FBE || mem[32] !== 16'h2061) begin
      errors++;
      $display("FAIL full_mem m0=%h m32=%h m63=%h required 0001 2061 3fbe", mem[0], mem[32], mem[63]);
    end
    checks++;
    if ({done, core_reset, error} !== 3'b100) begin
      errors++;
      $display("FAIL full_status done/crst/err=%b required 100", {done, core_reset, error});
    end
  endtask

  task automatic test_stalls();
    logic [7:0] s [0:6];
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hB1, 8'h0F, 8'h98};
    clear_mem();
    do_start();
    for (int i = 0; i < 7; i++) send_byte(s[i], int'($urandom_range(1, 4)));
    byte_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (mem[0] !== 16'h1234 || mem[1] !== 16'hB10F || we_cnt != 2 || done !== 1'b1) begin
      errors++;
      $display("FAIL stall_load m0=%h m1=%h writes=%0d done=%b required 1234 b10f 2 1",
               mem[0], mem[1], we_cnt, done);
    end
  endtask

  task automatic test_start_midload();
    clear_mem();
    do_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    // now in the write cycle: stray starts must not disturb the load
    byte_valid = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1 start = 1'b0;
    send_byte(8'hB1, 0);
    start = 1'b1;
    send_byte(8'h0F, 0);
    start = 1'b0;
    send_byte(8'h98, 0);
    byte_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (mem[0] !== 16'h1234 || mem[1] !== 16'hB10F || we_cnt != 2 || {done, error} !== 2'b10) begin
      errors++;
      $display("FAIL start_ignored m0=%h m1=%h writes=%0d done/err=%b required 1234 b10f 2 10",
               mem[0], mem[1], we_cnt, {done, error});
    end
  endtask

  task automatic test_restart_from_done();
    clear_mem();
    do_start();
    checks++;
    if (core_reset !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_restart crst=%b done=%b required 1 0", core_reset, done);
    end
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hAB, 0); send_byte(8'hCD, 0);
    send_byte(8'h66, 0);
    byte_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (mem[0] !== 16'hABCD || we_cnt != 1 || {done, core_reset, error} !== 3'b100) begin
      errors++;
      $display("FAIL second_load m0=%h writes=%0d done/crst/err=%b required abcd 1 100",
               mem[0], we_cnt, {done, core_reset, error});
    end
  endtask

  task automatic test_reset_midload();
    int n;
    clear_mem();
    do_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    byte_valid = 1'b0;
    n = 0;
    while (we_cnt < 1 && n < 20) begin @(negedge clock); n++; end
    checks++;
    if (we_cnt != 1) begin
      errors++;
      $display("FAIL midreset_word0 writes=%0d required 1", we_cnt);
    end
    @(negedge clock);
    reset = 1'b0;
    #2;
    checks++;
    if ({byte_ready, pm_we, core_reset, done, error} !== 5'b00100 || pm_addr !== '0) begin
      errors++;
      $display("FAIL midreset_state rdy/we/crst/done/err=%b addr=%0d required 00100 0",
               {byte_ready, pm_we, core_reset, done, error}, pm_addr);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (mem[0] !== 16'h1234 || byte_ready !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL midreset_idle m0=%h rdy=%b crst=%b required 1234 0 1", mem[0], byte_ready, core_reset);
    end
    clear_mem();
    do_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hB1, 0); send_byte(8'h0F, 0);
    send_byte(8'h98, 0);
    byte_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (mem[0] !== 16'h1234 || mem[1] !== 16'hB10F || {done, core_reset} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_reload m0=%h m1=%h done/crst=%b required 1234 b10f 10",
               mem[0], mem[1], {done, core_reset});
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_len_bounds(16'h0000);
    test_len_bounds(16'h0041);
    test_full_depth();
    test_stalls();
    test_start_midload();
    test_restart_from_done();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
